// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
// Access sizes, FSM states and the error data word.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } ram_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'h0;

  function automatic logic [2:0] size_bytes(input ram_size_e size);
    unique case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane.sv
// Byte-lane logic: store enables and merge, load extraction and extension.
// Lanes are relative to the request address, so no shifting is needed.
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  ram_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] load_data
);

  logic [31:0] mask;

  always_comb begin
    unique case (size)
      SIZE_BYTE: be = 4'b0001;
      SIZE_HALF: be = 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_word = (store_data & mask) | (raw & ~mask);

  always_comb begin
    unique case (size)
      SIZE_BYTE:
        load_data = is_unsigned ? {24'h0, raw[7:0]}
                                : {{24{raw[7]}}, raw[7:0]};
      SIZE_HALF:
        load_data = is_unsigned ? {16'h0, raw[15:0]}
                                : {{16{raw[15]}}, raw[15:0]};
      SIZE_WORD:
        load_data = raw;
      default:
        load_data = DMEM_ERR_DATA;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder with configurable wait states.
// One outstanding request; errors answer without touching memory.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wr_enable_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_error_o
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  dmem_state_e state, state_nx;
  logic [CW-1:0] count;

  logic [AW-1:0] addr_q;
  logic          wr_q;
  ram_size_e     size_q;
  logic          uns_q;
  logic [31:0]   data_q;

  logic [31:0] resp_data;
  logic        resp_error;

  logic [7:0] mem [MEM_SIZE];

  ram_size_e   req_size;
  logic [32:0] req_end;
  logic        req_fire;
  logic        req_err;
  logic        access;
  logic        resp_fire;

  logic [31:0] raw;
  logic [31:0] wr_word;
  logic [31:0] load_data;
  logic [3:0]  be;

  assign req_size = ram_size_e'(req_size_i);
  assign req_ready_o = (state == IDLE);
  assign req_fire = req_valid_i & req_ready_o;

  // 33-bit end address so accesses near 2^32 cannot wrap into range
  assign req_end = {1'b0, req_addr_i}
                 + {30'h0, size_bytes(req_size)};

  assign req_err =
      (req_size == SIZE_ILL)
    | ((req_size == SIZE_HALF) & req_addr_i[0])
    | ((req_size == SIZE_WORD) & (|req_addr_i[1:0]))
    | (req_end > 33'(MEM_SIZE));

  assign access = (state == WAIT) && (count == '0);
  assign resp_fire = (state == RESP) && resp_ready_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_fire) state_nx = req_err ? RESP : WAIT;
      WAIT: if (access) state_nx = RESP;
      RESP: if (resp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      size_q <= SIZE_BYTE;
      uns_q  <= 1'b0;
      data_q <= '0;
    end else if (req_fire) begin
      addr_q <= req_addr_i[AW-1:0];
      wr_q   <= req_wr_enable_i;
      size_q <= req_size;
      uns_q  <= req_unsigned_i;
      data_q <= req_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (req_fire) begin
      count <= CW'(WAIT_STATES);
    end else if ((state == WAIT) && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_data  <= DMEM_ERR_DATA;
      resp_error <= 1'b0;
    end else if (req_fire && req_err) begin
      resp_data  <= DMEM_ERR_DATA;
      resp_error <= 1'b1;
    end else if (access) begin
      resp_data  <= wr_q ? DMEM_ERR_DATA : load_data;
      resp_error <= 1'b0;
    end else if (resp_fire) begin
      resp_error <= 1'b0;
    end
  end

  // Lanes past the end of the array read as zero
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (int'(addr_q) + i < MEM_SIZE)
        raw[8*i +: 8] = mem[addr_q + AW'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (access && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[addr_q + AW'(i)] <= wr_word[8*i +: 8];
      end
    end
  end

  dmem_lane_unit u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (data_q),
    .raw         (raw),
    .be          (be),
    .wr_word     (wr_word),
    .load_data   (load_data)
  );

  assign resp_valid_o = (state == RESP);
  assign resp_data_o  = resp_data;
  assign resp_error_o = resp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Reference model is a plain byte array driven by the access rules.
module tb_dmem_responder;

  localparam int MS = 1024;
  localparam int WS = 2;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned model_mem [MS];

  dmem_responder #(
    .MEM_SIZE    (MS),
    .WAIT_STATES (WS)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_wr_enable_i (req_wr),
    .req_size_i      (req_size),
    .req_unsigned_i  (req_uns),
    .req_data_i      (req_data),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_data_o     (resp_data),
    .resp_error_o    (resp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_access(
    input  logic [31:0] a,
    input  logic        wr,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] d,
    output logic        err,
    output logic [31:0] rd
  );
    int     nb;
    longint la;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    la = a;
    err = (nb == 0) || ((la % nb) != 0) || (la + nb > MS);
    rd = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++)
          model_mem[la + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++)
          v = v | (32'(model_mem[la + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1])
          v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endfunction

  task automatic do_req(
    input  logic [31:0] a,
    input  logic        wr,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] d,
    input  int          hold,
    output logic [31:0] rdata,
    output logic        rerr,
    output int          lat
  );
    bit ok;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle got=%b want=1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_wr    = wr;
    req_size  = sz;
    req_uns   = uns;
    req_data  = d;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wr    = 1'($urandom);
    req_size  = 2'($urandom);
    req_data  = $urandom;
    ok  = 0;
    lat = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      lat++;
      if (resp_valid === 1'b1) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL resp_timeout addr=%h got=no_valid want=valid", a);
    end
    rdata = resp_data;
    rerr  = resp_error;
    repeat (hold) @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready);
    end
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid);
    end
    if (resp_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp_data got=%h want=0", resp_data);
    end
    if (resp_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_error got=%b want=0", resp_error);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ta [7] = '{32'h10, 32'h10, 32'h10, 32'h10,
                            32'h12, 32'h11, 32'h10};
    logic        tw [7] = '{1, 0, 0, 0, 0, 1, 0};
    logic [1:0]  ts [7] = '{2, 2, 0, 0, 1, 0, 2};
    logic        tu [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic [31:0] td [7] = '{32'hDEADBEEF, 0, 0, 0, 0, 32'h55, 0};
    logic [31:0] te [7] = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFEF,
                            32'h000000EF, 32'hFFFFDEAD, 32'h0,
                            32'hDEAD55EF};
    logic [31:0] rd, md;
    logic        re, me;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      model_access(ta[i], tw[i], ts[i], tu[i], td[i], me, md);
      do_req(ta[i], tw[i], ts[i], tu[i], td[i], 0, rd, re, lat);
      n_checks += 3;
      if (rd !== te[i]) begin
        n_fail++; $display("FAIL basic_data[%0d] got=%h want=%h", i, rd, te[i]);
      end
      if (re !== 1'b0) begin
        n_fail++; $display("FAIL basic_error[%0d] got=%b want=0", i, re);
      end
      if (lat != WS + 2) begin
        n_fail++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, lat, WS + 2);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ta [4] = '{32'h13, MS - 2, 32'h10, MS - 2};
    logic        tw [4] = '{0, 0, 0, 1};
    logic [1:0]  ts [4] = '{1, 2, 3, 2};
    logic [31:0] rd, md;
    logic        re, me;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      model_access(ta[i], tw[i], ts[i], 1'b0, 32'hCAFEF00D, me, md);
      do_req(ta[i], tw[i], ts[i], 1'b0, 32'hCAFEF00D, 0, rd, re, lat);
      n_checks += 3;
      if (re !== 1'b1) begin
        n_fail++; $display("FAIL err_flag[%0d] got=%b want=1", i, re);
      end
      if (rd !== 32'h0) begin
        n_fail++; $display("FAIL err_data[%0d] got=%h want=0", i, rd);
      end
      if (lat != 1) begin
        n_fail++; $display("FAIL err_latency[%0d] got=%0d want=1", i, lat);
      end
    end
    model_access(32'h10, 0, 2, 0, 0, me, md);
    do_req(32'h10, 0, 2, 0, 0, 0, rd, re, lat);
    n_checks++;
    if (rd !== md || re !== me) begin
      n_fail++; $display("FAIL err_mem_unchanged got=%h/%b want=%h/%b", rd, re, md, me);
    end
    model_access(MS - 4, 1, 2, 0, 32'hA5C3_0F96, me, md);
    do_req(MS - 4, 1, 2, 0, 32'hA5C3_0F96, 0, rd, re, lat);
    model_access(MS - 4, 0, 2, 0, 0, me, md);
    do_req(MS - 4, 0, 2, 0, 0, 0, rd, re, lat);
    n_checks++;
    if (rd !== 32'hA5C3_0F96 || re !== 1'b0) begin
      n_fail++; $display("FAIL top_word got=%h/%b want=a5c30f96/0", rd, re);
    end
  endtask

  task automatic test_hold();
    logic [31:0] md;
    logic        me;
    bit          ok;
    model_access(32'h10, 0, 2, 0, 0, me, md);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h10; req_wr = 1'b0;
    req_size = 2'd2; req_uns = 1'b0;
    @(posedge clock);
    #1;
    req_addr = 32'h40; req_wr = 1'b1; req_data = 32'h1111_2222;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL hold_timeout got=no_valid want=valid");
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== md ||
          resp_error !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got=v%b d%h e%b r%b want=v1 d%h e0 r0",
                 c, resp_valid, resp_data, resp_error, req_ready, md);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release got=r%b v%b e%b want=r1 v0 e0",
               req_ready, resp_valid, resp_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        re;
    int          lat;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h20; req_wr = 1'b1;
    req_size = 2'd2; req_data = 32'h12345678;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_data !== 32'h0 || resp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=r%b v%b d%h e%b want=r1 v0 d0 e0",
               req_ready, resp_valid, resp_data, resp_error);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    do_req(32'h20, 0, 2, 0, 0, 0, rd, re, lat);
    n_checks++;
    if (rd !== 32'h0 || re !== 1'b0) begin
      n_fail++; $display("FAIL midreset_mem got=%h/%b want=0/0", rd, re);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, md;
    logic [1:0]  sz;
    logic        wr, uns, re, me;
    int          lat;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, MS + 4));
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
      sz  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom);
      uns = 1'($urandom);
      d   = $urandom;
      model_access(a, wr, sz, uns, d, me, md);
      do_req(a, wr, sz, uns, d, $urandom_range(0, 3), rd, re, lat);
      n_checks += 3;
      if (rd !== md) begin
        n_fail++; $display("FAIL rand_data[%0d] a=%h got=%h want=%h", i, a, rd, md);
      end
      if (re !== me) begin
        n_fail++; $display("FAIL rand_error[%0d] a=%h got=%b want=%b", i, a, re, me);
      end
      if (lat != (me ? 1 : WS + 2)) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, me ? 1 : WS + 2);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_wr     = 1'b0;
    req_size   = 2'd0;
    req_uns    = 1'b0;
    req_data   = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    test_basic();
    test_errors();
    test_hold();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
